// File: rtl/byte_fifo_pkg.sv
// Shared constants for byte-stream blocks (SPI master, byte FIFO, UART).
package byte_fifo_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEPTH_LOG2_DEF = 4;

  // Pointer width: one extra MSB acts as the wrap bit for full/empty.
  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/byte_fifo_if.sv
// Put/full and get/empty handshake bundle shared by byte FIFOs and the SPI master.
interface byte_fifo_if
  import byte_fifo_pkg::*;
#(
  parameter int WIDTH = BYTE_W
);

  logic [WIDTH-1:0] in;
  logic             put;
  logic             full;
  logic [WIDTH-1:0] out;
  logic             get;
  logic             empty;

  modport master (output in, put, get, input  full, out, empty);
  modport slave  (input  in, put, get, output full, out, empty);

endinterface

// File: rtl/byte_fifo_ram.sv
// Simple dual-port register array: synchronous write, registered read.
// Array contents are never reset; only the read register is.
module byte_fifo_ram
  import byte_fifo_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int AW    = DEPTH_LOG2_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [WIDTH-1:0] r_rdata;

  // Write port: store the byte at the write address.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: load on accepted read, hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with put/full write side and get/empty read side.
// Optional occupancy output enabled by defining BYTE_FIFO_LEVEL_EN.
module byte_fifo
  import byte_fifo_pkg::*;
#(
  parameter int WIDTH      = BYTE_W,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic            clock,
  input  logic            reset,
  byte_fifo_if.slave      bus
`ifdef BYTE_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int PW = ptr_w(DEPTH_LOG2);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_wr_en;
  logic          w_rd_en;

  // Flags come only from registered pointers, so put/get never reach them
  // combinationally; requests are qualified by start-of-cycle flags.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-2:0] == r_rptr[PW-2:0]) &&
                   (r_wptr[PW-1] != r_rptr[PW-1]);
  assign w_wr_en = bus.put && !w_full;
  assign w_rd_en = bus.get && !w_empty;

  // Pointer advance on accepted requests; reset drops buffered bytes at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PW'(1);
      if (w_rd_en) r_rptr <= r_rptr + PW'(1);
    end
  end

  byte_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[PW-2:0]),
    .i_wdata (bus.in),
    .i_re    (w_rd_en),
    .i_raddr (r_rptr[PW-2:0]),
    .o_rdata (bus.out)
  );

  assign bus.empty = w_empty;
  assign bus.full  = w_full;

`ifdef BYTE_FIFO_LEVEL_EN
  assign level = r_wptr - r_rptr;
`endif

endmodule
